// File: rtl/arm7_pkg.sv
// Shared ARM7 core definitions.
// Holds the register index constants, the CPSR bit positions and the CPSR reset value.
package arm7_pkg;

  localparam int unsigned REG_W   = 32;
  localparam int unsigned NUM_REG = 16;

  localparam logic [3:0] REG_SP = 4'd13;
  localparam logic [3:0] REG_LR = 4'd14;
  localparam logic [3:0] REG_PC = 4'd15;

  // CPSR field positions
  localparam int unsigned CPSR_N      = 31;
  localparam int unsigned CPSR_Z      = 30;
  localparam int unsigned CPSR_C      = 29;
  localparam int unsigned CPSR_V      = 28;
  localparam int unsigned CPSR_I      = 7;
  localparam int unsigned CPSR_F      = 6;
  localparam int unsigned CPSR_T      = 5;
  localparam int unsigned CPSR_MODE_H = 4;
  localparam int unsigned CPSR_MODE_L = 0;

  // SVC mode with IRQ and FIQ masked
  localparam logic [31:0] RESET_CPSR_VAL = 32'h0000_00D3;

endpackage

// File: rtl/reg_bank_read_port.sv
// One registered read port of the register bank.
// Ports:
//   clk, rst_n      - clock and synchronous active-low reset
//   rd_en, rd_reg   - read strobe and register index
//   regs_flat       - all 16 committed registers, R0 in bits [31:0]
//   wr_en, wr_reg,
//   wr_value        - write port of the same edge, used for forwarding
//   rd_value        - read data, held until the next strobe
module reg_bank_read_port
  import arm7_pkg::*;
(
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       rd_en,
  input  logic [3:0]                 rd_reg,
  input  logic [NUM_REG*REG_W-1:0]   regs_flat,
  input  logic                       wr_en,
  input  logic [3:0]                 wr_reg,
  input  logic [REG_W-1:0]           wr_value,
  output logic [REG_W-1:0]           rd_value
);

  logic [REG_W-1:0] w_sel;
  logic [REG_W-1:0] r_value;

  always_comb begin
    w_sel = regs_flat[{rd_reg, 5'b0} +: REG_W];
    // A write landing on the same edge is returned instead of the stale value
    if (wr_en && (wr_reg == rd_reg)) begin
      w_sel = wr_value;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_value <= '0;
    end else if (rd_en) begin
      r_value <= w_sel;
    end
  end

  assign rd_value = r_value;

endmodule

// File: rtl/reg_bank.sv
// ARM7 register bank: R0-R15 (R15 = PC), CPSR and a single SPSR.
// Ports:
//   clk, rst_n                        - clock and synchronous active-low reset
//   reg_read_en/_reg/_value           - read port A, registered
//   reg_read_b_en/_b_reg/_b_value     - read port B, registered
//   reg_write_en/_reg/_value          - write port
//   reg_write_restore_from_SPSR       - with a write to R15, also CPSR <= SPSR
//   flags_write_en, flags_value       - NZCV update
//   spsr_write_en, spsr_write_value   - SPSR write
//   cpsr, spsr, pc                    - committed state
module reg_bank
  import arm7_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter logic [31:0] RESET_CPSR = RESET_CPSR_VAL
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        reg_read_en,
  input  logic [3:0]  reg_read_reg,
  output logic [31:0] reg_read_value,
  input  logic        reg_read_b_en,
  input  logic [3:0]  reg_read_b_reg,
  output logic [31:0] reg_read_b_value,
  input  logic        reg_write_en,
  input  logic [3:0]  reg_write_reg,
  input  logic [31:0] reg_write_value,
  input  logic        reg_write_restore_from_SPSR,
  input  logic        flags_write_en,
  input  logic [3:0]  flags_value,
  input  logic        spsr_write_en,
  input  logic [31:0] spsr_write_value,
  output logic [31:0] cpsr,
  output logic [31:0] spsr,
  output logic [31:0] pc
);

  logic [REG_W-1:0]         r_regs [NUM_REG];
  logic [REG_W-1:0]         r_cpsr;
  logic [REG_W-1:0]         r_spsr;
  logic [REG_W-1:0]         w_cpsr_d;
  logic [REG_W-1:0]         w_spsr_d;
  logic                     w_restore;
  logic [NUM_REG*REG_W-1:0] w_regs_flat;

  assign w_restore = reg_write_en && reg_write_restore_from_SPSR && (reg_write_reg == REG_PC);

  always_comb begin
    w_cpsr_d = r_cpsr;
    if (flags_write_en) begin
      w_cpsr_d[CPSR_N:CPSR_V] = flags_value;
    end
    // Restore overrides any flag update; CPSR takes the pre-edge SPSR exactly
    if (w_restore) begin
      w_cpsr_d = r_spsr;
    end
  end

  always_comb begin
    w_spsr_d = r_spsr;
    if (spsr_write_en) begin
      w_spsr_d = spsr_write_value;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REG - 1; i++) begin
        r_regs[i] <= '0;
      end
      r_regs[REG_PC] <= RESET_PC;
      r_cpsr         <= RESET_CPSR;
      r_spsr         <= '0;
    end else begin
      if (reg_write_en) begin
        r_regs[reg_write_reg] <= reg_write_value;
      end
      r_cpsr <= w_cpsr_d;
      r_spsr <= w_spsr_d;
    end
  end

  always_comb begin
    w_regs_flat = '0;
    for (int i = 0; i < NUM_REG; i++) begin
      w_regs_flat[i*REG_W +: REG_W] = r_regs[i];
    end
  end

  reg_bank_read_port u_read_a (
    .clk       (clk),
    .rst_n     (rst_n),
    .rd_en     (reg_read_en),
    .rd_reg    (reg_read_reg),
    .regs_flat (w_regs_flat),
    .wr_en     (reg_write_en),
    .wr_reg    (reg_write_reg),
    .wr_value  (reg_write_value),
    .rd_value  (reg_read_value)
  );

  reg_bank_read_port u_read_b (
    .clk       (clk),
    .rst_n     (rst_n),
    .rd_en     (reg_read_b_en),
    .rd_reg    (reg_read_b_reg),
    .regs_flat (w_regs_flat),
    .wr_en     (reg_write_en),
    .wr_reg    (reg_write_reg),
    .wr_value  (reg_write_value),
    .rd_value  (reg_read_b_value)
  );

  assign cpsr = r_cpsr;
  assign spsr = r_spsr;
  assign pc   = r_regs[REG_PC];

endmodule

// File: tb/tb_reg_bank.sv
// Directed self-checking bench for reg_bank.
module tb_reg_bank;

  logic        clk;
  logic        rst_n;
  logic        reg_read_en;
  logic [3:0]  reg_read_reg;
  logic [31:0] reg_read_value;
  logic        reg_read_b_en;
  logic [3:0]  reg_read_b_reg;
  logic [31:0] reg_read_b_value;
  logic        reg_write_en;
  logic [3:0]  reg_write_reg;
  logic [31:0] reg_write_value;
  logic        reg_write_restore_from_SPSR;
  logic        flags_write_en;
  logic [3:0]  flags_value;
  logic        spsr_write_en;
  logic [31:0] spsr_write_value;
  logic [31:0] cpsr;
  logic [31:0] spsr;
  logic [31:0] pc;

  int n_checks;
  int n_errors;

  reg_bank #(
    .RESET_PC   (32'h0000_0100),
    .RESET_CPSR (32'h0000_00D3)
  ) u_dut (
    .clk                         (clk),
    .rst_n                       (rst_n),
    .reg_read_en                 (reg_read_en),
    .reg_read_reg                (reg_read_reg),
    .reg_read_value              (reg_read_value),
    .reg_read_b_en               (reg_read_b_en),
    .reg_read_b_reg              (reg_read_b_reg),
    .reg_read_b_value            (reg_read_b_value),
    .reg_write_en                (reg_write_en),
    .reg_write_reg               (reg_write_reg),
    .reg_write_value             (reg_write_value),
    .reg_write_restore_from_SPSR (reg_write_restore_from_SPSR),
    .flags_write_en              (flags_write_en),
    .flags_value                 (flags_value),
    .spsr_write_en               (spsr_write_en),
    .spsr_write_value            (spsr_write_value),
    .cpsr                        (cpsr),
    .spsr                        (spsr),
    .pc                          (pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  task automatic clear_strobes();
    reg_read_en                 = 1'b0;
    reg_read_b_en               = 1'b0;
    reg_write_en                = 1'b0;
    reg_write_restore_from_SPSR = 1'b0;
    flags_write_en              = 1'b0;
    spsr_write_en               = 1'b0;
  endtask

  // One rising edge, then settle; strobes are dropped afterwards
  task automatic step();
    @(posedge clk);
    #1;
    clear_strobes();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    clear_strobes();
    reg_read_reg     = '0;
    reg_read_b_reg   = '0;
    reg_write_reg    = '0;
    reg_write_value  = '0;
    flags_value      = '0;
    spsr_write_value = '0;
    rst_n            = 1'b0;
    #2;
    do_reset();

    // 1: reset state, read R15, hold while idle
    check("rst_pc", pc, 32'h0000_0100);
    check("rst_cpsr", cpsr, 32'h0000_00D3);
    check("rst_spsr", spsr, 32'h0);
    check("rst_rda", reg_read_value, 32'h0);
    check("rst_rdb", reg_read_b_value, 32'h0);
    reg_read_en = 1'b1; reg_read_reg = 4'd15;
    step();
    check("rd_pc", reg_read_value, 32'h0000_0100);
    for (int i = 0; i < 5; i++) begin
      step();
      check("rd_hold", reg_read_value, 32'h0000_0100);
    end

    // 2: write R3 with same-edge reads on both ports
    reg_write_en = 1'b1; reg_write_reg = 4'd3; reg_write_value = 32'hDEAD_BEEF;
    reg_read_en = 1'b1; reg_read_reg = 4'd3;
    reg_read_b_en = 1'b1; reg_read_b_reg = 4'd3;
    step();
    check("fwd_a_r3", reg_read_value, 32'hDEAD_BEEF);
    check("fwd_b_r3", reg_read_b_value, 32'hDEAD_BEEF);
    reg_read_en = 1'b1; reg_read_reg = 4'd4;
    step();
    check("rd_r4", reg_read_value, 32'h0);
    check("hold_b_r3", reg_read_b_value, 32'hDEAD_BEEF);

    // 3: fetch-style R15 sequence
    reg_write_en = 1'b1; reg_write_reg = 4'd15; reg_write_value = 32'h0;
    step();
    reg_read_en = 1'b1; reg_read_reg = 4'd15;
    step();
    check("rd_pc0", reg_read_value, 32'h0);
    step();
    reg_write_en = 1'b1; reg_write_reg = 4'd15; reg_write_value = 32'h4;
    step();
    check("pc_4", pc, 32'h4);
    reg_read_en = 1'b1; reg_read_reg = 4'd15;
    step();
    check("rd_pc4", reg_read_value, 32'h4);
    reg_write_en = 1'b1; reg_write_reg = 4'd15; reg_write_value = 32'h8;
    reg_read_b_en = 1'b1; reg_read_b_reg = 4'd15;
    step();
    check("fwd_b_pc", reg_read_b_value, 32'h8);
    check("hold_a_pc", reg_read_value, 32'h4);
    check("pc_8", pc, 32'h8);

    // 4: restore beats flags
    spsr_write_en = 1'b1; spsr_write_value = 32'h6000_0010;
    step();
    check("spsr_wr", spsr, 32'h6000_0010);
    reg_write_en = 1'b1; reg_write_reg = 4'd15; reg_write_value = 32'h200;
    reg_write_restore_from_SPSR = 1'b1;
    flags_write_en = 1'b1; flags_value = 4'hF;
    step();
    check("restore_pc", pc, 32'h200);
    check("restore_cpsr", cpsr, 32'h6000_0010);
    // restore together with SPSR write: CPSR gets the old SPSR
    spsr_write_en = 1'b1; spsr_write_value = 32'h8000_0013;
    step();
    reg_write_en = 1'b1; reg_write_reg = 4'd15; reg_write_value = 32'h300;
    reg_write_restore_from_SPSR = 1'b1;
    spsr_write_en = 1'b1; spsr_write_value = 32'h1234_5678;
    step();
    check("rs_sw_cpsr", cpsr, 32'h8000_0013);
    check("rs_sw_spsr", spsr, 32'h1234_5678);
    check("rs_sw_pc", pc, 32'h300);

    // 5: flags update and ignored restores
    do_reset();
    check("rst2_cpsr", cpsr, 32'h0000_00D3);
    flags_write_en = 1'b1; flags_value = 4'h9;
    step();
    check("flags_9", cpsr, 32'h9000_00D3);
    reg_write_en = 1'b1; reg_write_reg = 4'd2; reg_write_value = 32'h0000_CAFE;
    reg_write_restore_from_SPSR = 1'b1;
    step();
    check("rs_r2_cpsr", cpsr, 32'h9000_00D3);
    reg_read_en = 1'b1; reg_read_reg = 4'd2;
    step();
    check("rd_r2", reg_read_value, 32'h0000_CAFE);
    reg_write_reg = 4'd15; reg_write_restore_from_SPSR = 1'b1;
    step();
    check("rs_noen_cpsr", cpsr, 32'h9000_00D3);
    check("rs_noen_pc", pc, 32'h0000_0100);

    // 6: reset beats strobes in the same cycle
    reg_write_en = 1'b1; reg_write_reg = 4'd1; reg_write_value = 32'h7;
    step();
    reg_read_b_en = 1'b1; reg_read_b_reg = 4'd1;
    step();
    check("rd_r1", reg_read_b_value, 32'h7);
    rst_n = 1'b0;
    reg_write_en = 1'b1; reg_write_reg = 4'd1; reg_write_value = 32'h5;
    spsr_write_en = 1'b1; spsr_write_value = 32'h0000_FFFF;
    reg_read_en = 1'b1; reg_read_reg = 4'd2;
    step();
    rst_n = 1'b1;
    check("rst_wr_spsr", spsr, 32'h0);
    check("rst_wr_rda", reg_read_value, 32'h0);
    check("rst_wr_rdb", reg_read_b_value, 32'h0);
    check("rst_wr_cpsr", cpsr, 32'h0000_00D3);
    reg_read_en = 1'b1; reg_read_reg = 4'd1;
    step();
    check("rst_wr_r1", reg_read_value, 32'h0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/reg_bank.md
Name: reg_bank

Overview:
- Responder side of the register-file protocol that the fetch and execute units drive.
- Holds R0–R15 (R15 = PC), CPSR and a single SPSR.
- Serves two registered read ports and one write port, plus a flags-update port for execute.
- One instance sits between fetch/decode/execute in the arm7 core. There is no mode banking: one SPSR and user-view registers only.

Parameters:
- RESET_PC, 32'h0000_0000, value loaded into R15 on reset
- RESET_CPSR, 32'h0000_00D3, value loaded into CPSR on reset (SVC mode, I/F set)

Ports:
- clk  in  1  core clock, all state updates on rising edge
- rst_n  in  1  synchronous active-low reset
- reg_read_en  in  1  port A read strobe (fetch/execute)
- reg_read_reg  in  4  port A register index
- reg_read_value  out  32  port A read data, registered
- reg_read_b_en  in  1  port B read strobe (execute operand 2)
- reg_read_b_reg  in  4  port B register index
- reg_read_b_value  out  32  port B read data, registered
- reg_write_en  in  1  write strobe
- reg_write_reg  in  4  write register index
- reg_write_value  in  32  write data
- reg_write_restore_from_SPSR  in  1  with write to R15: also copy SPSR into CPSR
- flags_write_en  in  1  update CPSR[31:28] (NZCV)
- flags_value  in  4  new NZCV
- spsr_write_en  in  1  write SPSR
- spsr_write_value  in  32  SPSR data
- cpsr  out  32  current CPSR, registered, continuously visible
- spsr  out  32  current SPSR, registered
- pc  out  32  current R15, registered (debug/trace)

Behaviour:
- Reset (rst_n=0 at a rising edge):
  - R0–R14 <= 0; R15 <= RESET_PC; CPSR <= RESET_CPSR; SPSR <= 0.
  - reg_read_value and reg_read_b_value <= 0.
  - Reset wins over every strobe in the same cycle. A read or write in flight at reset is dropped; nothing is committed.
- Read protocol, per port:
  - Read_en sampled high at edge E: the value for the indexed register is loaded into the output register at E and is valid from E until the next read on that port.
  - Latency is 1 cycle. The output holds when read_en is low; initiators may sample any later cycle.
- Write protocol:
  - Write_en high at edge E commits reg_write_value to reg_write_reg at E.
  - Single-cycle strobe; no acknowledge and no busy. The bank accepts one read per port and one write every cycle.
- Read/write collision:
  - A read and a write to the same index at the same edge return the new write value (write-through forwarding) on that port. This applies to both ports independently, including R15.
- Restore from SPSR:
  - write_en=1, reg=15, restore=1: R15 <= value and CPSR <= SPSR at the same edge.
  - restore=1 with reg != 15: the register write proceeds and restore is ignored.
  - restore=1 with write_en=0: ignored.
- Flags:
  - flags_write_en updates CPSR[31:28] only; other CPSR bits are unchanged.
  - Simultaneous restore and flags_write_en: restore wins, and CPSR = old SPSR exactly.
- SPSR:
  - spsr_write_en commits spsr_write_value.
  - Simultaneous spsr_write_en and restore: CPSR takes the old SPSR value, and SPSR takes the new value.
- Widths and arithmetic: all 32-bit, no arithmetic in this block. Indices are 4-bit, so every value is a valid register. R15 is stored as written; no alignment masking.
- Outputs cpsr, spsr and pc reflect committed state (post-edge), never the forwarded value.

Decomposition:
- Shared package (arm7_pkg):
  - register index constants (REG_SP=13, REG_LR=14, REG_PC=15)
  - CPSR field positions (N=31, Z=30, C=29, V=28, I=7, F=6, T=5, MODE=4:0)
  - the RESET_CPSR value
- Natural sub-module: reg_bank_read_port, instantiated twice. It contains the index mux, collision forwarding and output hold register.
- The write, PSR and restore logic stays in the top.

Test Plan:
1. Reset with RESET_PC=32'h100 → pc=32'h100 and cpsr=32'hD3. Then read_en with reg=15 → reg_read_value=32'h100 one edge later, and it holds 32'h100 for 5 idle cycles with read_en low.
2. Write R3=32'hDEADBEEF and, at the same edge, read port A R3 and port B R3 → both outputs = 32'hDEADBEEF after that edge. Next cycle, read R4 → 0.
3. Fetch-style sequence: read R15 (=0), wait one cycle, write R15=4 → the next read R15 returns 4, and pc=4.
4. spsr_write 32'h6000_0010; then write R15=32'h200 with restore=1 and flags_write_en=1, flags=4'hF at the same edge → pc=32'h200, cpsr=32'h6000_0010 (restore wins).
5. flags_write_en with flags=4'h9 and CPSR=32'hD3 → cpsr=32'h9000_00D3. restore=1 with reg=2 → R2 written, cpsr unchanged.
6. Assert rst_n=0 in the same cycle as a write R1=5 and spsr_write → R1=0, spsr=0, and the read outputs = 0 after the edge.
